// File: rtl/gf180mcu_osu_sc_serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
package gf180mcu_osu_sc_serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3_serial_sub_hsub.sv
// Combinational half subtractor: D = x - y (one bit), BO = borrow out.
module gf180mcu_osu_sc_hsub (
  input  logic i_x,
  input  logic i_y,
  output logic o_d,
  output logic o_bo
);

  assign o_d  = i_x ^ i_y;
  assign o_bo = ~i_x & i_y;

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3_serial_sub.sv
// Bit-serial unsigned subtractor DIFF = A - B, LSB first, one borrow flip-flop.
// Optional macro SERIAL_SUB_SAT_EN: clamp DIFF to zero when the final borrow is set.
module gf180mcu_osu_sc_gp12t3v3_serial_sub
  import gf180mcu_osu_sc_serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW
);

  localparam int                 CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-2:0]   r_res;
  logic               r_bor;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;

  logic               w_a;
  logic               w_b;
  logic               w_d0;
  logic               w_bo0;
  logic               w_d;
  logic               w_bo1;
  logic               w_bout;
  logic [WIDTH-1:0]   w_shift;

  assign w_a = r_a_sr[0];
  assign w_b = r_b_sr[0];

  // Full-subtract bit slice built from two half subtractors.
  gf180mcu_osu_sc_hsub u_hsub0 (
    .i_x  (w_a),
    .i_y  (w_b),
    .o_d  (w_d0),
    .o_bo (w_bo0)
  );

  gf180mcu_osu_sc_hsub u_hsub1 (
    .i_x  (w_d0),
    .i_y  (r_bor),
    .o_d  (w_d),
    .o_bo (w_bo1)
  );

  assign w_bout = w_bo0 | w_bo1;

  // New bit enters at the MSB; on the last edge this is the complete difference.
  assign w_shift = {w_d, r_res};

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res    <= '0;
      r_bor    <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (IN_VALID) begin
            r_a_sr  <= A;
            r_b_sr  <= B;
            r_res   <= '0;
            r_bor   <= 1'b0;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_bor  <= w_bout;
          r_cnt  <= r_cnt + CNT_W'(1);
          r_res  <= w_shift[WIDTH-1:1];
          if (r_cnt == LAST) begin
`ifdef SERIAL_SUB_SAT_EN
            r_diff <= w_bout ? '0 : w_shift;
`else
            r_diff <= w_shift;
`endif
            r_borrow <= w_bout;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign IN_READY  = (r_state == IDLE);
  assign OUT_VALID = (r_state == DONE);
  assign DIFF      = r_diff;
  assign BORROW    = r_borrow;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3_serial_sub.sv
// Scoreboard bench for the bit-serial subtractor with randomized operands and backpressure.
module tb_gf180mcu_osu_sc_gp12t3v3_serial_sub;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bor;
    int           cyc;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RN = 1'b0;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;
  logic [W-1:0] DIFF;
  logic         BORROW;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 2;   // 0 random, 1 hold low, 2 always high
  exp_t q[$];

  gf180mcu_osu_sc_gp12t3v3_serial_sub #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RN        (RN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .DIFF      (DIFF),
    .BORROW    (BORROW)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: plain unsigned arithmetic on the full operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   d;
    d      = int'(a) - int'(b);
    e.bor  = (int'(a) < int'(b));
    e.diff = W'(d & ((1 << W) - 1));
`ifdef SERIAL_SUB_SAT_EN
    if (e.bor) e.diff = '0;
`endif
    e.cyc  = 0;
    return e;
  endfunction

  // Consumer: drives OUT_READY shortly after each falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      case (rdy_mode)
        0:       OUT_READY = 1'($urandom_range(0, 1));
        1:       OUT_READY = 1'b0;
        default: OUT_READY = 1'b1;
      endcase
    end
  end

  // Monitor: pops the expected result when OUT_VALID rises, rechecks it every DONE cycle.
  exp_t cur;
  bit   have = 0;
  always @(negedge CLK) begin
    if (!RN) begin
      have = 0;
    end else if (OUT_VALID) begin
      if (!have) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 64'(OUT_VALID), 64'(0));
        end else begin
          cur  = q.pop_front();
          have = 1;
          chk("latency", 64'(cyc - cur.cyc), 64'(W));
        end
      end
      if (have) begin
        chk("diff", 64'(DIFF), 64'(cur.diff));
        chk("borrow", 64'(BORROW), 64'(cur.bor));
        chk("in_ready_in_done", 64'(IN_READY), 64'(0));
      end
    end else begin
      have = 0;
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n = 0;
    while (!IN_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) begin
      chk("issue_timeout", 64'(IN_READY), 64'(1));
      return;
    end
    A = a;
    B = b;
    IN_VALID = 1'b1;
    e = model(a, b);
    @(negedge CLK);
    IN_VALID = 1'b0;
    e.cyc = cyc;
    q.push_back(e);
    chk("in_ready_after_accept", 64'(IN_READY), 64'(0));
  endtask

  // Scrambles operands every cycle until the block is idle again.
  task automatic wait_idle();
    int n = 0;
    while (!IN_READY && n < 300) begin
      A = W'($urandom);
      B = W'($urandom);
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) chk("idle_timeout", 64'(IN_READY), 64'(1));
  endtask

  initial begin
    exp_t e;
    int   n;

    RN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_in_ready", 64'(IN_READY), 64'(1));
    chk("rst_out_valid", 64'(OUT_VALID), 64'(0));
    chk("rst_diff", 64'(DIFF), 64'(0));
    chk("rst_borrow", 64'(BORROW), 64'(0));
    RN = 1'b1;
    @(negedge CLK);

    rdy_mode = 2;
    issue(8'h5A, 8'h21); wait_idle();
    issue(8'h10, 8'h20); wait_idle();
    issue(8'hFF, 8'hFF); wait_idle();
    issue(8'h00, 8'h01); wait_idle();

    // Backpressure: result must hold and IN_VALID must be ignored in DONE.
    rdy_mode = 1;
    e = model(8'hC3, 8'h41);
    issue(8'hC3, 8'h41);
    n = 0;
    while (!OUT_VALID && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("bp_out_valid", 64'(OUT_VALID), 64'(1));
    for (int i = 0; i < 20; i++) begin
      IN_VALID = 1'b1;
      A = W'($urandom);
      B = W'($urandom);
      @(negedge CLK);
      chk("bp_out_valid_hold", 64'(OUT_VALID), 64'(1));
      chk("bp_in_ready", 64'(IN_READY), 64'(0));
    end
    IN_VALID = 1'b0;
    rdy_mode = 2;
    @(negedge CLK);
    chk("bp_release_in_ready", 64'(IN_READY), 64'(1));
    chk("bp_release_out_valid", 64'(OUT_VALID), 64'(0));
    chk("bp_release_diff_kept", 64'(DIFF), 64'(e.diff));

    // Reset after three SHIFT edges aborts the operation.
    issue(8'h77, 8'h12);
    repeat (3) @(negedge CLK);
    RN = 1'b0;
    #1;
    chk("abort_in_ready", 64'(IN_READY), 64'(1));
    chk("abort_out_valid", 64'(OUT_VALID), 64'(0));
    chk("abort_diff", 64'(DIFF), 64'(0));
    chk("abort_borrow", 64'(BORROW), 64'(0));
    if (q.size() > 0) void'(q.pop_back());
    repeat (2) @(negedge CLK);
    RN = 1'b1;
    @(negedge CLK);
    issue(8'h03, 8'h01); wait_idle();

    // Randomized operands with random consumer backpressure.
    rdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      issue(W'($urandom), W'($urandom));
      wait_idle();
    end
    rdy_mode = 2;
    issue(8'h00, 8'hFF); wait_idle();
    issue(8'hFF, 8'h00); wait_idle();

    repeat (3) @(negedge CLK);
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
